// File: rtl/ex_iter_pkg.sv
// Shared types and sizing helpers for the EX-stage iterative multiplier.
// Imported by the multiplier top and its partial-product step.
package ex_iter_pkg;

    typedef enum logic {ITER_MUL_LOW, ITER_MUL_HIGH} iter_mul_op_e;

    typedef enum logic [1:0] {ITER_IDLE, ITER_CALC, ITER_DONE} iter_state_e;

    function automatic int iter_count(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic int iter_cnt_w(input int width, input int bpc);
        return $clog2(width / bpc + 1);
    endfunction

endpackage

// File: rtl/ex_iter_mult_step.sv
// Combinational shift-add step: folds BITS_PER_CYCLE multiplier bits
// into the accumulator in one cycle.
module ex_iter_mult_step
    import ex_iter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [2*WIDTH-1:0]        acc,
    input  logic [2*WIDTH-1:0]        ma,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [2*WIDTH-1:0]        acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (bits[i]) begin
                acc_next = acc_next + (ma << i);
            end
        end
    end

endmodule

// File: rtl/ex_iter_mult.sv
// Iterative shift-add multiplier for the EX stage with early exit,
// result/tag hold until writeback, and flush.
module ex_iter_mult
    import ex_iter_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int TAG_W          = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  iter_mul_op_e       mul_op_i,
    input  logic [1:0]         signed_mode_i,
    input  logic [WIDTH-1:0]   operand_a_i,
    input  logic [WIDTH-1:0]   operand_b_i,
    input  logic [TAG_W-1:0]   waddr_i,
    input  logic               flush_i,
    input  logic               wb_ready_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   result_o,
    output logic [TAG_W-1:0]   waddr_o,
    output logic               multicycle_o
);

    localparam int ITERS = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = iter_cnt_w(WIDTH, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0 || WIDTH < 8) begin : g_bad_param
        $fatal(1, "ex_iter_mult: illegal WIDTH/BITS_PER_CYCLE");
    end

    iter_state_e          state_q;
    iter_mul_op_e         op_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   ma_q;
    logic [WIDTH-1:0]     mb_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     result_q;
    logic [TAG_W-1:0]     waddr_q;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 accept;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mb_next;
    logic [CNT_W-1:0]     cnt_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     res_sel;

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is
    // exactly its magnitude when read as unsigned.
    assign a_neg = signed_mode_i[0] & operand_a_i[WIDTH-1];
    assign b_neg = signed_mode_i[1] & operand_b_i[WIDTH-1];
    assign mag_a = a_neg ? -operand_a_i : operand_a_i;
    assign mag_b = b_neg ? -operand_b_i : operand_b_i;

    assign ready_o      = (state_q == ITER_IDLE);
    assign multicycle_o = (state_q != ITER_IDLE);
    assign valid_o      = (state_q == ITER_DONE);
    assign result_o     = result_q;
    assign waddr_o      = waddr_q;

    assign accept = en_i & ready_o & ~flush_i;

    ex_iter_mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .acc      (acc_q),
        .ma       (ma_q),
        .bits     (mb_q[BITS_PER_CYCLE-1:0]),
        .acc_next (acc_next)
    );

    assign mb_next  = mb_q >> BITS_PER_CYCLE;
    assign cnt_next = cnt_q + 1'b1;
    assign prod     = neg_q ? -acc_next : acc_next;
    assign res_sel  = (op_q == ITER_MUL_HIGH) ? prod[2*WIDTH-1:WIDTH]
                                              : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ITER_IDLE;
            op_q     <= ITER_MUL_LOW;
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            case (state_q)
                ITER_IDLE: begin
                    if (accept) begin
                        op_q    <= mul_op_i;
                        waddr_q <= waddr_i;
                        neg_q   <= a_neg ^ b_neg;
                        ma_q    <= {{WIDTH{1'b0}}, mag_a};
                        mb_q    <= mag_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        if (mag_a == '0 || mag_b == '0) begin
                            result_q <= '0;
                            state_q  <= ITER_DONE;
                        end else begin
                            state_q  <= ITER_CALC;
                        end
                    end
                end
                ITER_CALC: begin
                    if (flush_i) begin
                        state_q <= ITER_IDLE;
                    end else begin
                        acc_q <= acc_next;
                        ma_q  <= ma_q << BITS_PER_CYCLE;
                        mb_q  <= mb_next;
                        cnt_q <= cnt_next;
                        if (mb_next == '0 || cnt_next == ITERS_C) begin
                            result_q <= res_sel;
                            state_q  <= ITER_DONE;
                        end
                    end
                end
                ITER_DONE: begin
                    if (flush_i || wb_ready_i) begin
                        state_q <= ITER_IDLE;
                    end
                end
                default: state_q <= ITER_IDLE;
            endcase
        end
    end

endmodule
